// File: rtl/uart_receiver_pkg.sv
// -----------------------------------------------------------------------------
// uart_receiver_pkg
// Shared definitions for the UART receiver slice: RCSTA bit positions, receive
// FSM state encoding, oversampling constants, the FIFO entry layout and a
// 2-of-3 majority helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_receiver_pkg;

  // RCSTA bit positions: {SPEN, RX9, SREN, CREN, ADDEN, FERR, OERR, RX9D}
  localparam int RCSTA_SPEN  = 7;
  localparam int RCSTA_RX9   = 6;
  localparam int RCSTA_SREN  = 5;
  localparam int RCSTA_CREN  = 4;
  localparam int RCSTA_ADDEN = 3;
  localparam int RCSTA_FERR  = 2;
  localparam int RCSTA_OERR  = 1;
  localparam int RCSTA_RX9D  = 0;

  localparam int OVERSAMPLE = 16;

  typedef logic [$clog2(OVERSAMPLE)-1:0] tick_t;

  // Each bit is voted on from three samples around its centre.
  localparam tick_t TICK_S0   = tick_t'(7);
  localparam tick_t TICK_S1   = tick_t'(8);
  localparam tick_t TICK_S2   = tick_t'(9);
  localparam tick_t TICK_LAST = tick_t'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_BIT9  = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       ferr;
    logic       bit9;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Groups the serial input, baud strobe and register-bus signals of the UART
// receiver.
//   master : drives UART_RXD, rx_sample_en, reg_data_in, rcsta_reg_wr_en,
//            rcreg_reg_rd_en; observes rcsta_reg_out, rcreg_reg_out, rxif_set_en
//   slave  : the receiver side (mirror of master)
// -----------------------------------------------------------------------------
interface uart_receiver_if;
  logic       UART_RXD;
  logic       rx_sample_en;
  logic [7:0] reg_data_in;
  logic       rcsta_reg_wr_en;
  logic [7:0] rcsta_reg_out;
  logic       rcreg_reg_rd_en;
  logic [7:0] rcreg_reg_out;
  logic       rxif_set_en;

  modport master (
    output UART_RXD, rx_sample_en, reg_data_in, rcsta_reg_wr_en, rcreg_reg_rd_en,
    input  rcsta_reg_out, rcreg_reg_out, rxif_set_en
  );

  modport slave (
    input  UART_RXD, rx_sample_en, reg_data_in, rcsta_reg_wr_en, rcreg_reg_rd_en,
    output rcsta_reg_out, rcreg_reg_out, rxif_set_en
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Two-entry receive FIFO of {ferr, bit9, data}. Entry 0 is always the head.
// A pop and a push in the same cycle are applied pop-first, so a full FIFO
// that is read while a frame lands does not overrun.
//   clk, rst  : clock, synchronous active-high reset
//   flush_i   : empties the FIFO (takes priority over push/pop)
//   push_i    : write wdata_i
//   pop_i     : discard the head entry (ignored while empty)
//   wdata_i   : entry to push
//   head_o    : head entry (meaningful only while !empty_o)
//   full_o    : two entries held
//   empty_o   : no entries held
//   drop_o    : push arrived with no room; the entry was discarded
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_receiver_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  rx_entry_t wdata_i,
  output rx_entry_t head_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  rx_entry_t  mem_q [2];
  rx_entry_t  mem_d [2];
  logic [1:0] count_q, count_d;

  // NOTE: every signal written here gets a default first; otherwise a path
  // that skips the assignment makes synthesis infer a latch.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    drop_o  = 1'b0;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i && count_q != 2'd0) begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - 2'd1;
      end
      if (push_i) begin
        if (count_d == 2'd2) begin
          drop_o = 1'b1;
        end else begin
          mem_d[count_d[0]] = wdata_i;
          count_d           = count_d + 2'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // NOTE: the storage is deliberately not reset; count_q alone defines which
  // entries are valid, and unreset storage maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[0];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 16x-oversampling UART receiver with an RCSTA control/status register, an
// RCREG read port and a two-entry receive FIFO.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : uart_receiver_if.slave
//            UART_RXD        async serial input, idle high
//            rx_sample_en    16x baud strobe
//            reg_data_in     register write data
//            rcsta_reg_wr_en RCSTA write strobe
//            rcsta_reg_out   {SPEN, RX9, SREN=0, CREN, ADDEN, FERR, OERR, RX9D}
//            rcreg_reg_rd_en RCREG read strobe (pops the FIFO)
//            rcreg_reg_out   data byte at the FIFO head
//            rxif_set_en     high while the FIFO is non-empty
// Optional feature: define UART_RX_ADDEN_EN to enable address detection
// (ADDEN=1 with RX9=1 discards frames whose ninth bit is 0).
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_receiver_pkg::*;
(
  input logic            clk,
  input logic            rst,
  uart_receiver_if.slave bus
);

  // ---------------------------------------------------------------- sync ---
  logic sync1_q, sync2_q, rxd_s;

  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.UART_RXD;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

  // ------------------------------------------------------------- control ---
  logic       spen_q, rx9_q, cren_q, oerr_q, oerr_d, adden;
  logic [7:0] rcreg_last_q;
  logic       cren_fall, abort;

  logic       fifo_push, fifo_full, fifo_empty, fifo_drop;
  rx_entry_t  fifo_head, fifo_wdata;

  // Clearing CREN or holding SPEN low kills any frame in flight.
  assign cren_fall = bus.rcsta_reg_wr_en && cren_q && !bus.reg_data_in[RCSTA_CREN];
  assign abort     = !spen_q || cren_fall;

  always_comb begin
    oerr_d = oerr_q;
    if (abort) begin
      oerr_d = 1'b0;
    end else if (fifo_drop) begin
      oerr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spen_q       <= 1'b0;
      rx9_q        <= 1'b0;
      cren_q       <= 1'b0;
      oerr_q       <= 1'b0;
      rcreg_last_q <= 8'h00;
    end else begin
      if (bus.rcsta_reg_wr_en) begin
        spen_q <= bus.reg_data_in[RCSTA_SPEN];
        rx9_q  <= bus.reg_data_in[RCSTA_RX9];
        cren_q <= bus.reg_data_in[RCSTA_CREN];
      end
      oerr_q <= oerr_d;
      // Remembers what RCREG showed so it holds once the FIFO drains.
      if (!fifo_empty) begin
        rcreg_last_q <= fifo_head.data;
      end
    end
  end

`ifdef UART_RX_ADDEN_EN
  logic adden_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      adden_q <= 1'b0;
    end else if (bus.rcsta_reg_wr_en) begin
      adden_q <= bus.reg_data_in[RCSTA_ADDEN];
    end
  end
  assign adden = adden_q;
`else
  assign adden = 1'b0;
`endif

  // ----------------------------------------------------------------- FSM ---
  rx_state_e  state_q, state_d;
  tick_t      tick_q, tick_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] shift_q, shift_d;
  logic       bit9_q, bit9_d;
  logic       maj, push_frame, addr_reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      bit9_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      bit9_q    <= bit9_d;
    end
  end

  // Vote uses the two stored samples plus the live one at TICK_S2.
  assign maj = majority3(samp_q[0], samp_q[1], rxd_s);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    bit9_d     = bit9_q;
    push_frame = 1'b0;

    if (abort) begin
      state_d   = ST_IDLE;
      tick_d    = '0;
      bit_cnt_d = '0;
    end else if (bus.rx_sample_en) begin
      if (state_q != ST_IDLE) begin
        tick_d = tick_q + tick_t'(1);
        if (tick_q == TICK_S0) samp_d[0] = rxd_s;
        if (tick_q == TICK_S1) samp_d[1] = rxd_s;
      end

      unique case (state_q)
        ST_IDLE: begin
          // The detecting sample is tick 0 of the start bit.
          if (!rxd_s && cren_q && !oerr_q) begin
            state_d   = ST_START;
            tick_d    = tick_t'(1);
            bit_cnt_d = '0;
            bit9_d    = 1'b0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_S2 && maj) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end else if (tick_q == TICK_LAST) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_S2) shift_d = {maj, shift_q[7:1]};
          if (tick_q == TICK_LAST) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = rx9_q ? ST_BIT9 : ST_STOP;
          end
        end
        ST_BIT9: begin
          if (tick_q == TICK_S2) bit9_d = maj;
          if (tick_q == TICK_LAST) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (tick_q == TICK_S2) begin
            push_frame = 1'b1;
            state_d    = ST_IDLE;
            tick_d     = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_ADDEN_EN
  assign addr_reject = adden && rx9_q && !bit9_q;
`else
  assign addr_reject = 1'b0;
`endif

  assign fifo_push  = push_frame && !addr_reject;
  assign fifo_wdata = '{ferr: ~maj, bit9: rx9_q & bit9_q, data: shift_q};

  uart_rx_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (!spen_q),
    .push_i  (fifo_push),
    .pop_i   (bus.rcreg_reg_rd_en),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // ------------------------------------------------------------- outputs ---
  logic [7:0] rcsta;

  always_comb begin
    rcsta              = '0;
    rcsta[RCSTA_SPEN]  = spen_q;
    rcsta[RCSTA_RX9]   = rx9_q;
    rcsta[RCSTA_SREN]  = 1'b0;
    rcsta[RCSTA_CREN]  = cren_q;
    rcsta[RCSTA_ADDEN] = adden;
    rcsta[RCSTA_FERR]  = !fifo_empty && fifo_head.ferr;
    rcsta[RCSTA_OERR]  = oerr_q;
    rcsta[RCSTA_RX9D]  = !fifo_empty && fifo_head.bit9;
  end

  assign bus.rcsta_reg_out = rcsta;
  assign bus.rcreg_reg_out = fifo_empty ? rcreg_last_q : fifo_head.data;
  assign bus.rxif_set_en   = !fifo_empty;

  // Only used to document FIFO state; keeps the full flag observable.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver: drives serial frames at 16 strobes per
// bit (strobe every second clock) and checks RCSTA/RCREG/RXIF.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  uart_receiver_if bus ();

  uart_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // 16x strobe: high on every second rising edge, changed on falling edges.
  always @(negedge clk) begin
    if (rst) bus.rx_sample_en = 1'b0;
    else     bus.rx_sample_en = ~bus.rx_sample_en;
  end

`ifdef UART_RX_ADDEN_EN
  localparam logic [7:0] ADDEN_RD = 8'h08;
`else
  localparam logic [7:0] ADDEN_RD = 8'h00;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after the n-th strobe edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (bus.rx_sample_en !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_rcsta(input logic [7:0] v);
    bus.reg_data_in     = v;
    bus.rcsta_reg_wr_en = 1'b1;
    clk1();
    bus.rcsta_reg_wr_en = 1'b0;
  endtask

  task automatic pop();
    bus.rcreg_reg_rd_en = 1'b1;
    clk1();
    bus.rcreg_reg_rd_en = 1'b0;
  endtask

  // Start at a strobe boundary; the receiver pushes 11 strobes into the stop
  // bit, so pop_at_push raises the read strobe on exactly that edge.
  task automatic send_frame(input logic [7:0] d, input bit use9, input bit b9,
                            input bit stop, input bit pop_at_push);
    bus.UART_RXD = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.UART_RXD = d[i];
      wait_ticks(16);
    end
    if (use9) begin
      bus.UART_RXD = b9;
      wait_ticks(16);
    end
    bus.UART_RXD = stop;
    if (pop_at_push) begin
      wait_ticks(10);
      clk1();
      bus.rcreg_reg_rd_en = 1'b1;
      clk1();
      bus.rcreg_reg_rd_en = 1'b0;
      wait_ticks(5);
    end else begin
      wait_ticks(16);
    end
    bus.UART_RXD = 1'b1;
  endtask

  initial begin
    bus.UART_RXD        = 1'b1;
    bus.reg_data_in     = 8'h00;
    bus.rcsta_reg_wr_en = 1'b0;
    bus.rcreg_reg_rd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    clk1();

    // Reset state
    check("rst_rcsta", bus.rcsta_reg_out, 8'h00);
    check("rst_rcreg", bus.rcreg_reg_out, 8'h00);
    check("rst_rxif",  bus.rxif_set_en,   8'h00);

    // RCSTA write; SREN/FERR/OERR/RX9D bits are not writable
    wr_rcsta(8'hB7);
    check("wr_ro_bits", bus.rcsta_reg_out, 8'h90);
    wr_rcsta(8'h90);
    wait_ticks(4);

    // Basic 8-bit frame
    send_frame(8'h5A, 0, 0, 1, 0);
    check("5a_rxif",  bus.rxif_set_en,   8'h01);
    check("5a_rcreg", bus.rcreg_reg_out, 8'h5A);
    check("5a_rcsta", bus.rcsta_reg_out, 8'h90);
    pop();
    check("5a_pop_rxif",  bus.rxif_set_en,   8'h00);
    check("5a_pop_hold",  bus.rcreg_reg_out, 8'h5A);
    pop();
    check("empty_pop_hold", bus.rcreg_reg_out, 8'h5A);

    // 9-bit frame
    wr_rcsta(8'hD0);
    send_frame(8'h3C, 1, 1, 1, 0);
    check("3c_rcreg", bus.rcreg_reg_out, 8'h3C);
    check("3c_rx9d",  bus.rcsta_reg_out, 8'hD1);
    pop();
    check("3c_pop_rcsta", bus.rcsta_reg_out, 8'hD0);

    // Overrun
    wr_rcsta(8'h90);
    send_frame(8'h11, 0, 0, 1, 0);
    send_frame(8'h22, 0, 0, 1, 0);
    check("full_no_oerr", bus.rcsta_reg_out, 8'h90);
    send_frame(8'h33, 0, 0, 1, 0);
    check("ov_oerr",  bus.rcsta_reg_out, 8'h92);
    check("ov_head1", bus.rcreg_reg_out, 8'h11);
    pop();
    check("ov_head2", bus.rcreg_reg_out, 8'h22);
    send_frame(8'h44, 0, 0, 1, 0);
    check("ov_blocked_head", bus.rcreg_reg_out, 8'h22);
    pop();
    check("ov_blocked_rxif", bus.rxif_set_en, 8'h00);
    wr_rcsta(8'h80);
    check("cren_clr_oerr", bus.rcsta_reg_out, 8'h80);
    wr_rcsta(8'h90);
    wait_ticks(4);

    // Framing error, then a short glitch
    send_frame(8'hA5, 0, 0, 0, 0);
    check("fe_rcsta", bus.rcsta_reg_out, 8'h94);
    check("fe_rcreg", bus.rcreg_reg_out, 8'hA5);
    wait_ticks(20);
    pop();
    check("fe_pop_rcsta", bus.rcsta_reg_out, 8'h90);
    bus.UART_RXD = 1'b0;
    wait_ticks(4);
    bus.UART_RXD = 1'b1;
    wait_ticks(20);
    check("glitch_rxif", bus.rxif_set_en, 8'h00);
    send_frame(8'h77, 0, 0, 1, 0);
    check("after_glitch", bus.rcreg_reg_out, 8'h77);
    pop();

    // Pop on the same edge as a push into a full FIFO
    send_frame(8'h11, 0, 0, 1, 0);
    send_frame(8'h22, 0, 0, 1, 0);
    send_frame(8'h33, 0, 0, 1, 1);
    check("pp_oerr",  bus.rcsta_reg_out, 8'h90);
    check("pp_head1", bus.rcreg_reg_out, 8'h22);
    pop();
    check("pp_head2", bus.rcreg_reg_out, 8'h33);
    pop();
    check("pp_empty", bus.rxif_set_en, 8'h00);

    // SPEN=0 flushes
    send_frame(8'h55, 0, 0, 1, 0);
    check("spen_pre", bus.rxif_set_en, 8'h01);
    wr_rcsta(8'h00);
    clk1();
    check("spen_flush", bus.rxif_set_en,   8'h00);
    check("spen_rcsta", bus.rcsta_reg_out, 8'h00);
    check("spen_hold",  bus.rcreg_reg_out, 8'h55);

    // Address detection
    wr_rcsta(8'hD8);
    check("adden_rd", bus.rcsta_reg_out, 8'hD0 | ADDEN_RD);
    wait_ticks(4);
    send_frame(8'h40, 1, 0, 1, 0);
`ifdef UART_RX_ADDEN_EN
    check("addr_drop_rxif",  bus.rxif_set_en,   8'h00);
    check("addr_drop_rcsta", bus.rcsta_reg_out, 8'hD8);
`else
    check("noaddr_rcreg", bus.rcreg_reg_out, 8'h40);
    pop();
`endif
    send_frame(8'h41, 1, 1, 1, 0);
    check("addr_keep_rcreg", bus.rcreg_reg_out, 8'h41);
    check("addr_keep_rcsta", bus.rcsta_reg_out, 8'hD1 | ADDEN_RD);
    pop();

    // Reset mid-frame
    wr_rcsta(8'h90);
    bus.UART_RXD = 1'b0;
    wait_ticks(40);
    rst = 1'b1;
    repeat (3) clk1();
    rst = 1'b0;
    bus.UART_RXD = 1'b1;
    clk1();
    check("midrst_rcsta", bus.rcsta_reg_out, 8'h00);
    check("midrst_rcreg", bus.rcreg_reg_out, 8'h00);
    wr_rcsta(8'h90);
    wait_ticks(200);
    check("midrst_nopush", bus.rxif_set_en, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 UART_RXD  in  1  async serial input, idle high.
REQ-004 rx_sample_en  in  1  one-clk strobe at 16x baud, from the baud generator.
REQ-005 reg_data_in  in  8  shared register write bus.
REQ-006 rcsta_reg_wr_en  in  1  write strobe for RCSTA.
REQ-007 rcsta_reg_out  out  8  {SPEN, RX9, SREN=0, CREN, ADDEN, FERR, OERR, RX9D}.
REQ-008 rcreg_reg_rd_en  in  1  one-clk read strobe for RCREG; pops the FIFO.
REQ-009 rcreg_reg_out  out  8  data byte at the FIFO head.
REQ-010 rxif_set_en  out  1  level, high while the FIFO is non-empty.

Function
REQ-011 UART_RXD passes through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-012 FSM states IDLE, START, DATA, BIT9, STOP; it advances only on rx_sample_en; tick counter runs 0..15 per bit.
REQ-013 Each bit value is the 2-of-3 majority of samples at ticks 7, 8 and 9.
REQ-014 IDLE->START on a sampled low while SPEN=1, CREN=1 and OERR=0.
REQ-015 START: a majority value of 1 is a false start and returns to IDLE; otherwise the FSM enters DATA at the tick-15 boundary.
REQ-016 DATA shifts 8 bits LSB-first, then goes to BIT9 if RX9=1, else to STOP.
REQ-017 STOP samples the stop bit; FERR_entry = (stop==0). The entry {FERR, bit9, byte} is pushed at tick 9, then the FSM returns to IDLE.
REQ-018 The FIFO holds 2 entries; FERR and RX9D always reflect the head entry and read 0 when the FIFO is empty.
REQ-019 A push while the FIFO is full drops the entry and sets OERR; while OERR=1, no new frames start.
REQ-020 A simultaneous push and pop while full pops first, then pushes: no overrun.
REQ-021 A pop while empty has no effect; rcreg_reg_out holds its last value.
REQ-022 An RCSTA write updates SPEN, RX9, CREN and ADDEN only; FERR, OERR and RX9D are read-only.
REQ-023 CREN 1->0 clears OERR and aborts any frame in progress (FSM->IDLE, no push); the FIFO is kept.
REQ-024 SPEN=0 holds the FSM in IDLE, flushes the FIFO and clears OERR.

Reset
REQ-025 rst: all RCSTA bits 0, FSM=IDLE, counters 0, FIFO empty, rcreg_reg_out=8'h00, rxif_set_en=0, synchronizer flops=1.
REQ-026 rst mid-frame discards the frame and does not push.

Configuration
REQ-027 With UART_RX_ADDEN_EN defined: if ADDEN=1 and RX9=1, frames with bit9=0 are discarded without setting OERR or FERR.
REQ-028 Without UART_RX_ADDEN_EN: ADDEN is not stored, reads 0, and all frames are pushed.

Structure
REQ-029 A shared package holds RCSTA bit indices, FSM state encodings, OVERSAMPLE=16 and the sample tick indices 7, 8 and 9.
REQ-030 The 2-entry 10-bit FIFO is sub-module uart_rx_fifo (push, pop, full, empty, head).

Verification
REQ-031 SPEN=CREN=1, RX9=0, frame 0x5A with valid stop -> after stop tick 9 rxif_set_en=1, RCREG=0x5A, FERR=0; pop -> rxif_set_en=0.
REQ-032 RX9=1, 0x3C with bit9=1 -> RX9D=1, RCREG=0x3C.
REQ-033 3 frames 0x11, 0x22, 0x33 with no reads -> OERR=1; pops return 0x11 then 0x22; clearing CREN clears OERR.
REQ-034 Frame 0xA5 with stop=0 -> FERR=1 while at head; 4-tick low glitch on UART_RXD -> no push.
REQ-035 Pop asserted on the same clk as the 3rd push while full -> OERR=0, FIFO contents 0x22, 0x33.
REQ-036 With UART_RX_ADDEN_EN, ADDEN=RX9=1: 0x40 with bit9=0 is dropped; 0x41 with bit9=1 is pushed.
